// File: rtl/rx_elastic_reader.sv
// rx_elastic_reader
//   Read side of an elastic buffer. Drains the FIFO into a continuous symbol
//   stream with no bubbles. When the FIFO runs low, it replicates idle words
//   (never data) to let the write side catch up. When the FIFO runs dry, or
//   draining is disabled, it falls back to FILL and streams idle words.
//
// Ports
//   rclk, rrst_n    read clock, asynchronous active-low reset
//   enable          high allows draining; low forces FILL
//   rdata           FIFO head word, valid when rempty=0
//   rempty          registered FIFO empty flag
//   r_almost_empty  registered FIFO almost-empty flag
//   rinc            FIFO pop request (combinational)
//   out_data        registered output word
//   out_is_fill     high when out_data was inserted rather than popped
//   underflow       one-cycle pulse when the FIFO empties while running
//   ins_count       saturating count of idle insertions
//   ufl_count       saturating count of underflow events
module rx_elastic_reader #(
    parameter int unsigned      DSIZE     = 18,
    parameter logic [DSIZE-1:0] IDLE_WORD = 18'h2BC50,
    parameter int unsigned      INS_CNT_W = 16
) (
    input  logic                 rclk,
    input  logic                 rrst_n,
    input  logic                 enable,
    input  logic [DSIZE-1:0]     rdata,
    input  logic                 rempty,
    input  logic                 r_almost_empty,
    output logic                 rinc,
    output logic [DSIZE-1:0]     out_data,
    output logic                 out_is_fill,
    output logic                 underflow,
    output logic [INS_CNT_W-1:0] ins_count,
    output logic [7:0]           ufl_count
);

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           next_state;
    logic             pop;
    logic [DSIZE-1:0] next_data;
    logic             next_fill;
    logic             next_ufl;
    logic             ins_inc;
    logic             ufl_inc;
    logic             head_is_idle;

    // Full-width compare: a data word whose symbols match the idle symbols
    // but whose K-flags differ must not be replicated.
    assign head_is_idle = (rdata == IDLE_WORD);

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        next_data  = IDLE_WORD;
        next_fill  = 1'b1;
        next_ufl   = 1'b0;
        ins_inc    = 1'b0;
        ufl_inc    = 1'b0;
        unique case (state)
            FILL: begin
                // Entering RUN costs one idle cycle; the first pop happens in RUN.
                if (enable && !r_almost_empty && !rempty)
                    next_state = RUN;
            end
            RUN: begin
                if (!enable) begin
                    next_state = FILL;
                end else if (rempty) begin
                    next_state = FILL;
                    next_ufl   = 1'b1;
                    ufl_inc    = 1'b1;
                end else if (r_almost_empty && head_is_idle) begin
                    // Idle stays at the head, so this repeats while low.
                    ins_inc = 1'b1;
                end else begin
                    pop       = 1'b1;
                    next_data = rdata;
                    next_fill = 1'b0;
                end
            end
            default: next_state = FILL;
        endcase
    end

    // Reset gate keeps rinc low for the whole reset interval, independent of
    // how quickly the state register settles.
    assign rinc = pop & rrst_n;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state       <= FILL;
            out_data    <= IDLE_WORD;
            out_is_fill <= 1'b1;
            underflow   <= 1'b0;
            ins_count   <= '0;
            ufl_count   <= '0;
        end else begin
            state       <= next_state;
            out_data    <= next_data;
            out_is_fill <= next_fill;
            underflow   <= next_ufl;
            if (ins_inc && (ins_count != '1))
                ins_count <= ins_count + 1'b1;
            if (ufl_inc && (ufl_count != '1))
                ufl_count <= ufl_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_rx_elastic_reader.sv
// tb_rx_elastic_reader
//   Directed bench for rx_elastic_reader with hand-computed expectations.
//   Inputs change 1 ns after the rising edge; rinc is checked mid-cycle,
//   registered outputs are checked after the edge that updates them.
module tb_rx_elastic_reader;

    localparam logic [17:0] IDLE = 18'h2BC50;

    logic        rclk = 1'b0;
    logic        rrst_n;
    logic        enable;
    logic [17:0] rdata;
    logic        rempty;
    logic        r_almost_empty;
    logic        rinc;
    logic [17:0] out_data;
    logic        out_is_fill;
    logic        underflow;
    logic [15:0] ins_count;
    logic [7:0]  ufl_count;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    rx_elastic_reader #(
        .DSIZE     (18),
        .IDLE_WORD (18'h2BC50),
        .INS_CNT_W (16)
    ) dut (
        .rclk           (rclk),
        .rrst_n         (rrst_n),
        .enable         (enable),
        .rdata          (rdata),
        .rempty         (rempty),
        .r_almost_empty (r_almost_empty),
        .rinc           (rinc),
        .out_data       (out_data),
        .out_is_fill    (out_is_fill),
        .underflow      (underflow),
        .ins_count      (ins_count),
        .ufl_count      (ufl_count)
    );

    always #5 rclk = ~rclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge rclk);
        #1;
    endtask

    // Apply inputs and let combinational logic settle (still well before the edge).
    task automatic drive(input logic en, input logic emp, input logic ae, input logic [17:0] d);
        enable         = en;
        rempty         = emp;
        r_almost_empty = ae;
        rdata          = d;
        #1;
    endtask

    initial begin
        rrst_n = 1'b0;
        drive(1'b0, 1'b1, 1'b1, 18'h00000);
        #2;
        check("rst_rinc", rinc, 0);
        step();
        check("rst_data", out_data, IDLE);
        check("rst_fill", out_is_fill, 1);
        check("rst_ufl", underflow, 0);
        check("rst_ins", ins_count, 0);
        check("rst_uflc", ufl_count, 0);
        rrst_n = 1'b1;

        // Empty FIFO after reset: idle stream, never pop.
        drive(1'b1, 1'b1, 1'b1, 18'h3FFFF);
        for (int i = 0; i < 10; i++) begin
            check("empty_rinc", rinc, 0);
            step();
            check("empty_data", out_data, IDLE);
            check("empty_fill", out_is_fill, 1);
        end

        // Fill -> run transition, then two popped words.
        drive(1'b1, 1'b0, 1'b0, 18'h00102);
        check("trans_rinc", rinc, 0);
        step();
        check("trans_data", out_data, IDLE);
        check("trans_fill", out_is_fill, 1);
        check("pop1_rinc", rinc, 1);
        step();
        check("pop1_data", out_data, 18'h00102);
        check("pop1_fill", out_is_fill, 0);
        drive(1'b1, 1'b0, 1'b0, 18'h00304);
        check("pop2_rinc", rinc, 1);
        step();
        check("pop2_data", out_data, 18'h00304);
        check("pop2_fill", out_is_fill, 0);

        // Almost empty with idle at head: three insertions.
        drive(1'b1, 1'b0, 1'b1, IDLE);
        for (int i = 0; i < 3; i++) begin
            check("ins_rinc", rinc, 0);
            step();
            check("ins_data", out_data, IDLE);
            check("ins_fill", out_is_fill, 1);
        end
        check("ins_cnt3", ins_count, 3);

        // Almost empty with data at head: popped, not held.
        drive(1'b1, 1'b0, 1'b1, 18'h01234);
        check("ae_data_rinc", rinc, 1);
        step();
        check("ae_data_out", out_data, 18'h01234);
        check("ae_data_fill", out_is_fill, 0);
        check("ae_data_ins", ins_count, 3);

        // Idle symbols with a differing K-flag are data, not idle.
        drive(1'b1, 1'b0, 1'b1, 18'h0BC50);
        check("kflag_rinc", rinc, 1);
        step();
        check("kflag_out", out_data, 18'h0BC50);
        check("kflag_fill", out_is_fill, 0);
        check("kflag_ins", ins_count, 3);

        // Underflow: FIFO empties while running.
        drive(1'b1, 1'b1, 1'b1, 18'h00777);
        check("ufl_rinc", rinc, 0);
        step();
        check("ufl_pulse", underflow, 1);
        check("ufl_cnt1", ufl_count, 1);
        check("ufl_data", out_data, IDLE);
        check("ufl_fill", out_is_fill, 1);
        check("ufl_fill_rinc", rinc, 0);
        step();
        check("ufl_pulse_end", underflow, 0);

        // 299 more underflows saturate the counter at 255.
        for (int i = 0; i < 299; i++) begin
            drive(1'b1, 1'b0, 1'b0, 18'h00001);
            step();
            drive(1'b1, 1'b1, 1'b1, 18'h00001);
            step();
        end
        check("ufl_sat", ufl_count, 255);
        step();
        check("ufl_sat_quiet", underflow, 0);
        check("ufl_sat_ins", ins_count, 3);

        // Disable while running: back to FILL without an underflow.
        drive(1'b1, 1'b0, 1'b0, 18'h00AAA);
        step();
        drive(1'b0, 1'b0, 1'b0, 18'h00AAA);
        check("dis_rinc", rinc, 0);
        step();
        check("dis_ufl", underflow, 0);
        check("dis_fill", out_is_fill, 1);
        check("dis_uflc", ufl_count, 255);
        check("dis_stay_rinc", rinc, 0);

        // Reset mid-run with a pop pending.
        drive(1'b1, 1'b0, 1'b0, 18'h00555);
        step();
        check("pre_rst_rinc", rinc, 1);
        #1;
        rrst_n = 1'b0;
        #1;
        check("midrst_rinc", rinc, 0);
        check("midrst_data", out_data, IDLE);
        check("midrst_fill", out_is_fill, 1);
        check("midrst_ins", ins_count, 0);
        check("midrst_uflc", ufl_count, 0);
        step();
        check("inrst_rinc", rinc, 0);
        check("inrst_data", out_data, IDLE);
        rrst_n = 1'b1;
        #1;
        check("post_rst_rinc", rinc, 0);
        step();
        check("post_rst_fill", out_is_fill, 1);
        check("post_rst_run", rinc, 1);
        step();
        check("post_rst_data", out_data, 18'h00555);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
